// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine controller and its change dispenser.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } chg_state_e;

  localparam int AMT_W = 6;

  localparam logic [1:0] COIN_TYPE_LO  = 2'd0;
  localparam logic [1:0] COIN_TYPE_MID = 2'd1;
  localparam logic [1:0] COIN_TYPE_HI  = 2'd2;

  localparam int COIN_HI_VAL  = 10;
  localparam int COIN_MID_VAL = 5;
  localparam int COIN_LO_VAL  = 1;

  localparam int PRICE_WATER = 15;
  localparam int PRICE_SODA  = 25;
  localparam int PRICE_JUICE = 35;

endpackage

// File: rtl/change_dispenser_if.sv
// Upstream amount handshake plus coin hopper request/ack and status flags.
interface change_dispenser_if;
  import vending_pkg::*;

  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic             coin_req;
  logic [1:0]       coin_type;
  logic             coin_ack;
  logic             busy;
  logic             done;
  logic             fault;

  modport master (
    output change_valid, change_amount, coin_ack,
    input  change_ready, coin_req, coin_type, busy, done, fault
  );

  modport slave (
    input  change_valid, change_amount, coin_ack,
    output change_ready, coin_req, coin_type, busy, done, fault
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Picks the largest denomination not exceeding the remaining amount (purely combinational).
module coin_select
  import vending_pkg::*;
#(
  parameter int COIN_HI  = COIN_HI_VAL,
  parameter int COIN_MID = COIN_MID_VAL,
  parameter int COIN_LO  = COIN_LO_VAL
) (
  input  logic [AMT_W-1:0] remaining,
  output logic [1:0]       coin_type,
  output logic [AMT_W-1:0] coin_value
);

  localparam logic [AMT_W-1:0] HI_V  = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] MID_V = AMT_W'(COIN_MID);
  localparam logic [AMT_W-1:0] LO_V  = AMT_W'(COIN_LO);

  always_comb begin
    coin_type  = COIN_TYPE_LO;
    coin_value = LO_V;
    if (remaining >= HI_V) begin
      coin_type  = COIN_TYPE_HI;
      coin_value = HI_V;
    end else if (remaining >= MID_V) begin
      coin_type  = COIN_TYPE_MID;
      coin_value = MID_V;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout through a coin hopper, one coin per req/ack handshake.
// Optional hopper stall detection under macro CHG_ACK_TIMEOUT_EN.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int COIN_HI  = COIN_HI_VAL,
  parameter int COIN_MID = COIN_MID_VAL,
  parameter int COIN_LO  = COIN_LO_VAL
`ifdef CHG_ACK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  chg_state_e       state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       sel_type;
  logic [AMT_W-1:0] sel_value;

  coin_select #(
    .COIN_HI  (COIN_HI),
    .COIN_MID (COIN_MID),
    .COIN_LO  (COIN_LO)
  ) u_coin_select (
    .remaining  (remaining_q),
    .coin_type  (sel_type),
    .coin_value (sel_value)
  );

`ifdef CHG_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef CHG_ACK_TIMEOUT_EN
    // Held at zero outside REQ, so every REQ entry starts a fresh wait.
    tmo_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.change_valid) begin
          remaining_d = bus.change_amount;
          state_d     = (bus.change_amount == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - sel_value;
          state_d     = (remaining_q == sel_value) ? ST_DONE : ST_GAP;
        end
`ifdef CHG_ACK_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) state_d = ST_FAULT;
        end
`endif
      end
      ST_GAP:   state_d = ST_REQ;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
`ifdef CHG_ACK_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
`ifdef CHG_ACK_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Outputs decode registered state only; coin_type parks at LO outside REQ.
  assign bus.change_ready = (state_q == ST_IDLE);
  assign bus.coin_req     = (state_q == ST_REQ);
  assign bus.coin_type    = (state_q == ST_REQ) ? sel_type : COIN_TYPE_LO;
  assign bus.busy         = (state_q == ST_REQ) || (state_q == ST_GAP) || (state_q == ST_FAULT);
  assign bus.done         = (state_q == ST_DONE);
`ifdef CHG_ACK_TIMEOUT_EN
  assign bus.fault        = (state_q == ST_FAULT);
`else
  assign bus.fault        = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coins/done pulses queued by stimulus, checked by a monitor.
module tb_change_dispenser;
  import vending_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;
  int exp_coin[$];
  int exp_done = 0;
  int hs_cnt   = 0;
  int hop_en   = 1;
  int ack_delay = 0;

  logic       gap_pend  = 1'b0;
  logic       prev_req  = 1'b0;
  logic       prev_ack  = 1'b0;
  logic [1:0] prev_type = 2'd0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name, string what);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Hopper model: acks ack_delay cycles after seeing a request, holds ack for one cycle.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.coin_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.coin_ack) begin
        bus.coin_ack = 1'b0;
        wcnt = 0;
      end else if (hop_en != 0 && bus.coin_req) begin
        if (wcnt >= ack_delay) begin
          bus.coin_ack = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the expected coin on each handshake and the expected done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gap_pend) chk("gap_low", int'(bus.coin_req), 0);
        gap_pend = 1'b0;
        if (bus.coin_req) begin
          chk("busy_during_req", int'(bus.busy), 1);
          if (prev_req && !prev_ack) chk("type_stable", int'(bus.coin_type), int'(prev_type));
        end
        if (bus.coin_req && bus.coin_ack) begin
          if (exp_coin.size() == 0) fail_now("unexpected_coin", $sformatf("got type %0d expected none", bus.coin_type));
          else chk("coin_type", int'(bus.coin_type), exp_coin.pop_front());
          hs_cnt++;
          gap_pend = 1'b1;
        end
        if (bus.done) begin
          if (exp_done == 0) fail_now("unexpected_done", "got done pulse expected none");
          else begin
            n_checks++;
            exp_done--;
          end
        end
      end
      prev_req  = bus.coin_req;
      prev_ack  = bus.coin_ack;
      prev_type = bus.coin_type;
    end
  end

  task automatic send(int amt);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.change_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("ready_timeout", "change_ready never rose");
    bus.change_valid  = 1'b1;
    bus.change_amount = 6'(amt);
    @(posedge clk);
    #1;
    bus.change_valid  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_done > 0 || exp_coin.size() > 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("payout_timeout", $sformatf("%0d coins and %0d done pending", exp_coin.size(), exp_done));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.change_valid  = 1'b0;
    bus.change_amount = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_change_ready", int'(bus.change_ready), 1);
    chk("rst_coin_req",     int'(bus.coin_req), 0);
    chk("rst_coin_type",    int'(bus.coin_type), 0);
    chk("rst_busy",         int'(bus.busy), 0);
    chk("rst_done",         int'(bus.done), 0);
    chk("rst_fault",        int'(bus.fault), 0);
    @(negedge clk);
    reset = 1'b0;

    // 37 with 1-cycle ack delay: 10,10,10,5,1,1
    ack_delay = 1;
    exp_coin = '{2, 2, 2, 1, 0, 0};
    exp_done = 1;
    send(37);
    chk("req_latency_37", int'(bus.coin_req), 1);
    wait_done();
    chk("remaining_37", int'(dut.remaining_q), 0);

    // Zero amount: done straight away, no request
    exp_done = 1;
    send(0);
    chk("zero_done",     int'(bus.done), 1);
    chk("zero_coin_req", int'(bus.coin_req), 0);
    chk("zero_ready_lo", int'(bus.change_ready), 0);
    @(posedge clk);
    #1;
    chk("zero_done_end", int'(bus.done), 0);
    chk("zero_ready_hi", int'(bus.change_ready), 1);
    wait_done();

    // 63 with 5-cycle ack delay: six HI then three LO
    ack_delay = 5;
    exp_coin = '{2, 2, 2, 2, 2, 2, 0, 0, 0};
    exp_done = 1;
    send(63);
    chk("req_latency_63", int'(bus.coin_req), 1);
    wait_done();
    chk("remaining_63", int'(dut.remaining_q), 0);

    // 15 with zero-wait hopper; an amount of 20 offered mid-payout must be ignored
    ack_delay = 0;
    exp_coin = '{2, 1};
    exp_done = 1;
    send(15);
    @(negedge clk);
    chk("busy_ignore", int'(bus.busy), 1);
    chk("ready_while_busy", int'(bus.change_ready), 0);
    bus.change_valid  = 1'b1;
    bus.change_amount = 6'd20;
    @(posedge clk);
    #1;
    bus.change_valid  = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("ignore_no_payout", int'(bus.busy), 0);

    // Reset after two coins of 37: payout discarded, no done pulse
    ack_delay = 1;
    hs_cnt = 0;
    exp_coin = '{2, 2, 2, 1, 0, 0};
    exp_done = 1;
    send(37);
    begin
      int t;
      t = 0;
      while (hs_cnt < 2 && t < 200) begin
        @(posedge clk);
        t++;
      end
      if (t >= 200) fail_now("mid_reset_wait", "two coins never dispensed");
    end
    #1;
    reset = 1'b1;
    exp_coin.delete();
    exp_done = 0;
    @(posedge clk);
    #1;
    chk("mrst_state",     int'(dut.state_q), int'(ST_IDLE));
    chk("mrst_coin_req",  int'(bus.coin_req), 0);
    chk("mrst_ready",     int'(bus.change_ready), 1);
    chk("mrst_busy",      int'(bus.busy), 0);
    chk("mrst_remaining", int'(dut.remaining_q), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mrst_done", int'(bus.done), 0);

    // Stalled hopper on amount 10
    hop_en = 0;
    send(10);
`ifdef CHG_ACK_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_fault_early", int'(bus.fault), 0);
    chk("tmo_req_early",   int'(bus.coin_req), 1);
    @(posedge clk);
    #1;
    chk("tmo_fault",     int'(bus.fault), 1);
    chk("tmo_coin_req",  int'(bus.coin_req), 0);
    chk("tmo_busy",      int'(bus.busy), 1);
    chk("tmo_ready",     int'(bus.change_ready), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("tmo_sticky",    int'(bus.fault), 1);
`else
    repeat (30) @(posedge clk);
    #1;
    chk("stall_fault",   int'(bus.fault), 0);
    chk("stall_req",     int'(bus.coin_req), 1);
    chk("stall_type",    int'(bus.coin_type), 2);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hop_en = 1;
    @(negedge clk);
    chk("post_rst_fault", int'(bus.fault), 0);
    chk("post_rst_ready", int'(bus.change_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
